uart_rx_core: RTL and testbench

UART_RX_CORE -- requirements
Module: uart_rx_core

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_fifo.sv | 127 ++++++++++++
 rtl/uart_rx_core.sv | 170 +++++++++++++++++
 tb/tb_uart_rx_core.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART receiver types: FSM state encoding, FIFO entry layout and the
// lookup for how many bits follow the start bit.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BRK
    } rx_state_e;

    typedef struct packed {
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } rx_entry_t;

    // Data bits (7 or 8) plus the optional parity bit.
    function automatic logic [3:0] frame_bits(input logic eight, input logic pen);
        return 4'd7 + {3'b000, eight} + {3'b000, pen};
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive storage for uart_rx_core. With UART_RX_FIFO_EN defined it is a DEPTH-entry
// FIFO; otherwise a single holding register with the same push/pop/overflow rules.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  rx_entry_t                    push_data,
    input  logic                         pop,
    output rx_entry_t                    head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         ovf
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic pop_ok;
    logic push_ok;
    logic ovf_q, ovf_d;

`ifdef UART_RX_FIFO_EN
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rx_entry_t        mem_q [DEPTH];
    rx_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty;
    logic             full;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CNT_W'(1);
        end
        if (push && !push_ok) begin
            ovf_d = 1'b1;
        end else if (pop_ok) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    assign head  = empty ? '0 : mem_q[rd_ptr_q];
    assign count = count_q;
`else
    rx_entry_t hold_q, hold_d;
    logic      full_q, full_d;

    assign pop_ok  = pop && full_q;
    assign push_ok = push && (!full_q || pop_ok);

    always_comb begin
        hold_d = hold_q;
        full_d = full_q;
        ovf_d  = ovf_q;
        if (pop_ok) begin
            full_d = 1'b0;
        end
        if (push_ok) begin
            hold_d = push_data;
            full_d = 1'b1;
        end
        if (push && !push_ok) begin
            ovf_d = 1'b1;
        end else if (pop_ok) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q <= '0;
            full_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            full_q <= full_d;
            ovf_q  <= ovf_d;
        end
    end

    assign head  = full_q ? hold_q : '0;
    assign count = CNT_W'(full_q);
`endif

    assign ovf = ovf_q;

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: rx synchroniser, framing FSM with per-frame latched settings, and
// receive storage (multi-entry FIFO only when UART_RX_FIFO_EN is defined).
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DIV_W       = 19
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DIV_W-1:0]                  baud_div,
    input  logic                              eight,
    input  logic                              pen,
    input  logic                              ohel,
    input  logic                              rx,
    input  logic                              reads,
    output logic [7:0]                        rdata,
    output logic                              rx_rdy,
    output logic                              perr,
    output logic                              ferr,
    output logic                              ovf,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rx_s;

    rx_state_e        state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic             eight_q, eight_d;
    logic             pen_q, pen_d;
    logic             ohel_q, ohel_d;
    logic [7:0]       data_q, data_d;
    logic             par_q, par_d;

    logic             tick;
    logic [3:0]       n_data;
    logic [3:0]       n_bits;
    logic             exp_par;
    logic             push;
    rx_entry_t        push_entry;
    rx_entry_t        head;

    assign sync_d  = {sync_q[SYNC_STAGES-2:0], rx};
    assign rx_s    = sync_q[SYNC_STAGES-1];
    assign tick    = (cnt_q == div_q);
    assign n_data  = eight_q ? 4'd8 : 4'd7;
    assign n_bits  = frame_bits(eight_q, pen_q);
    // Bit 7 stays 0 in 7-bit frames, so the full-byte XOR is correct in both modes.
    assign exp_par = (^data_q) ^ ohel_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        bit_cnt_d  = bit_cnt_q;
        eight_d    = eight_q;
        pen_d      = pen_q;
        ohel_d     = ohel_q;
        data_d     = data_q;
        par_d      = par_q;
        push       = 1'b0;
        push_entry = '0;
        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d   = ST_START;
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    div_d     = (baud_div < DIV_W'(3)) ? DIV_W'(3) : baud_div;
                    eight_d   = eight;
                    pen_d     = pen;
                    ohel_d    = ohel;
                    data_d    = '0;
                    par_d     = 1'b0;
                end
            end
            ST_START: begin
                if (cnt_q == (div_q >> 1)) begin
                    cnt_d   = '0;
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            ST_DATA: begin
                if (tick) begin
                    cnt_d = '0;
                    if (bit_cnt_q < n_data) begin
                        data_d[bit_cnt_q[2:0]] = rx_s;
                    end else begin
                        par_d = rx_s;
                    end
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == n_bits - 4'd1) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            ST_STOP: begin
                if (tick) begin
                    cnt_d           = '0;
                    push            = 1'b1;
                    push_entry.data = data_q;
                    push_entry.perr = pen_q & (par_q ^ exp_par);
                    push_entry.ferr = ~rx_s;
                    state_d         = rx_s ? ST_IDLE : ST_BRK;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            ST_BRK: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q    <= '1;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            div_q     <= '0;
            bit_cnt_q <= '0;
            eight_q   <= 1'b0;
            pen_q     <= 1'b0;
            ohel_q    <= 1'b0;
            data_q    <= '0;
            par_q     <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            eight_q   <= eight_d;
            pen_q     <= pen_d;
            ohel_q    <= ohel_d;
            data_q    <= data_d;
            par_q     <= par_d;
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (reads),
        .head      (head),
        .count     (fifo_count),
        .ovf       (ovf)
    );

    assign rdata  = head.data;
    assign perr   = head.perr;
    assign ferr   = head.ferr;
    assign rx_rdy = (fifo_count != '0);

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: serial frames driven bit by bit, received entries checked
// against a queue model of the receive storage.
module tb_uart_rx_core;

    localparam int DEPTH = 4;
`ifdef UART_RX_FIFO_EN
    localparam int EFF_DEPTH = DEPTH;
`else
    localparam int EFF_DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [18:0] baud_div;
    logic        eight, pen, ohel, rx, reads;
    logic [7:0]  rdata;
    logic        rx_rdy, perr, ferr, ovf;
    logic [2:0]  fifo_count;
    logic [14:0] obs;

    int          checks = 0;
    int          errors = 0;
    logic [9:0]  model_q [$];
    logic        model_ovf;

    uart_rx_core #(
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (2),
        .DIV_W       (19)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .baud_div   (baud_div),
        .eight      (eight),
        .pen        (pen),
        .ohel       (ohel),
        .rx         (rx),
        .reads      (reads),
        .rdata      (rdata),
        .rx_rdy     (rx_rdy),
        .perr       (perr),
        .ferr       (ferr),
        .ovf        (ovf),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    assign obs = {rx_rdy, ovf, fifo_count, ferr, perr, rdata};

    function automatic logic par_of(input logic [7:0] m, input logic oh);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(m[i]);
        return ((ones % 2) == 1) ^ oh;
    endfunction

    function automatic logic [9:0] make_entry(input logic [7:0] d, input logic e8, input logic pe,
                                              input logic oh, input logic pbit, input logic stopbit);
        logic [7:0] m;
        m = e8 ? d : {1'b0, d[6:0]};
        return {~stopbit, pe && (pbit != par_of(m, oh)), m};
    endfunction

    function automatic logic [14:0] exp_obs();
        logic [9:0] h;
        h = (model_q.size() > 0) ? model_q[0] : 10'd0;
        return {model_q.size() > 0, model_ovf, 3'(model_q.size()), h};
    endfunction

    task automatic model_push(input logic [9:0] e);
        if (model_q.size() < EFF_DEPTH) model_q.push_back(e);
        else model_ovf = 1'b1;
    endtask

    task automatic model_pop();
        if (model_q.size() > 0) begin
            void'(model_q.pop_front());
            model_ovf = 1'b0;
        end
    endtask

    task automatic pulse_read();
        @(negedge clk);
        reads = 1'b1;
        @(negedge clk);
        reads = 1'b0;
        model_pop();
    endtask

    task automatic drain();
        repeat (EFF_DEPTH + 1) pulse_read();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic e8, input logic pe, input logic oh,
                              input logic pbit, input logic stopbit, input int div);
        int bc;
        bc = ((div < 3) ? 3 : div) + 1;
        baud_div = 19'(div);
        eight    = e8;
        pen      = pe;
        ohel     = oh;
        @(negedge clk);
        rx = 1'b0;
        repeat (bc) @(negedge clk);
        // settings changed mid-frame must only affect later frames
        baud_div = 19'($urandom_range(0, 40));
        eight    = 1'($urandom_range(0, 1));
        pen      = 1'($urandom_range(0, 1));
        ohel     = 1'($urandom_range(0, 1));
        for (int i = 0; i < (e8 ? 8 : 7); i++) begin
            rx = d[i];
            repeat (bc) @(negedge clk);
        end
        if (pe) begin
            rx = pbit;
            repeat (bc) @(negedge clk);
        end
        rx = stopbit;
        repeat (stopbit ? bc : 30 * bc) @(negedge clk);
        rx = 1'b1;
        repeat (2 * bc + 4) @(negedge clk);
        model_push(make_entry(d, e8, pe, oh, pbit, stopbit));
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #1;
        checks++;
        if (obs !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs obs=%h exp=%h", obs, 15'd0);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (obs !== exp_obs()) begin
            errors++;
            $display("FAIL after_reset obs=%h exp=%h", obs, exp_obs());
        end
    endtask

    task automatic test_basic();
        drain();
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9);
        checks++;
        if (obs !== exp_obs()) begin
            errors++;
            $display("FAIL basic_a5 obs=%h exp=%h", obs, exp_obs());
        end
        checks++;
        if ({rx_rdy, rdata, fifo_count, perr, ferr} !== {1'b1, 8'hA5, 3'd1, 2'b00}) begin
            errors++;
            $display("FAIL basic_a5_fields rdata=%h count=%0d perr=%b ferr=%b exp A5/1/0/0", rdata, fifo_count, perr, ferr);
        end
    endtask

    task automatic test_parity();
        for (int p = 0; p < 2; p++) begin
            drain();
            send_frame(8'h41, 1'b0, 1'b1, 1'b1, 1'(p), 1'b1, 9);
            checks++;
            if (obs !== exp_obs()) begin
                errors++;
                $display("FAIL parity_odd_%0d obs=%h exp=%h", p, obs, exp_obs());
            end
            checks++;
            if ({rdata, perr} !== {8'h41, (p == 0)}) begin
                errors++;
                $display("FAIL parity_perr_%0d rdata=%h perr=%b exp 41/%b", p, rdata, perr, (p == 0));
            end
        end
    endtask

    task automatic test_clamp();
        int divs [3] = '{1, 0, 3};
        logic [7:0] ds [3] = '{8'h3C, 8'hC3, 8'hFE};
        for (int k = 0; k < 3; k++) begin
            drain();
            send_frame(ds[k], (k != 2), 1'b1, 1'b0, par_of(ds[k] & ((k != 2) ? 8'hFF : 8'h7F), 1'b0), 1'b1, divs[k]);
            checks++;
            if (obs !== exp_obs()) begin
                errors++;
                $display("FAIL clamp_div%0d obs=%h exp=%h", divs[k], obs, exp_obs());
            end
        end
    endtask

    task automatic test_false_start();
        drain();
        baud_div = 19'd9;
        @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (obs !== exp_obs()) begin
            errors++;
            $display("FAIL false_start obs=%h exp=%h", obs, exp_obs());
        end
        send_frame(8'h96, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9);
        checks++;
        if (obs !== exp_obs()) begin
            errors++;
            $display("FAIL after_false_start obs=%h exp=%h", obs, exp_obs());
        end
    endtask

    task automatic test_break();
        drain();
        send_frame(8'hF0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9);
        checks++;
        if (obs !== exp_obs()) begin
            errors++;
            $display("FAIL break_entry obs=%h exp=%h", obs, exp_obs());
        end
        send_frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9);
        checks++;
        if (obs !== exp_obs()) begin
            errors++;
            $display("FAIL after_break obs=%h exp=%h", obs, exp_obs());
        end
    endtask

    task automatic test_overflow();
        drain();
        for (int v = 1; v <= 5; v++) send_frame(8'(v), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9);
        checks++;
        if (obs !== exp_obs()) begin
            errors++;
            $display("FAIL overflow_full obs=%h exp=%h", obs, exp_obs());
        end
        for (int k = 0; k < EFF_DEPTH; k++) begin
            pulse_read();
            checks++;
            if (obs !== exp_obs()) begin
                errors++;
                $display("FAIL overflow_pop%0d obs=%h exp=%h", k, obs, exp_obs());
            end
        end
    endtask

    task automatic test_rst_mid();
        drain();
        send_frame(8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9);
        baud_div = 19'd9;
        eight    = 1'b1;
        pen      = 1'b0;
        @(negedge clk);
        rx = 1'b0;
        repeat (10) @(negedge clk);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        rx = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        model_q.delete();
        model_ovf = 1'b0;
        checks++;
        if (obs !== 15'd0) begin
            errors++;
            $display("FAIL rst_mid_data obs=%h exp=%h", obs, 15'd0);
        end
        @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9);
        checks++;
        if (obs !== exp_obs()) begin
            errors++;
            $display("FAIL rst_then_5a obs=%h exp=%h", obs, exp_obs());
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       e8, pe, oh, pb;
        int         div;
        for (int n = 0; n < 24; n++) begin
            d   = 8'($urandom);
            e8  = 1'($urandom_range(0, 1));
            pe  = 1'($urandom_range(0, 1));
            oh  = 1'($urandom_range(0, 1));
            div = $urandom_range(0, 12);
            pb  = par_of(e8 ? d : {1'b0, d[6:0]}, oh);
            if ($urandom_range(0, 3) == 0) pb = ~pb;
            send_frame(d, e8, pe, oh, pb, 1'b1, div);
            checks++;
            if (obs !== exp_obs()) begin
                errors++;
                $display("FAIL random_frame%0d obs=%h exp=%h", n, obs, exp_obs());
            end
            if ($urandom_range(0, 1) == 1) begin
                pulse_read();
                checks++;
                if (obs !== exp_obs()) begin
                    errors++;
                    $display("FAIL random_pop%0d obs=%h exp=%h", n, obs, exp_obs());
                end
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        rx        = 1'b1;
        reads     = 1'b0;
        baud_div  = 19'd9;
        eight     = 1'b1;
        pen       = 1'b0;
        ohel      = 1'b0;
        model_ovf = 1'b0;
        test_reset();
        test_basic();
        test_parity();
        test_clamp();
        test_false_start();
        test_break();
        test_overflow();
        test_rst_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
